// File: rtl/ctrl_hazard_tracker_pkg.sv
// Shared types for the ID-stage hazard tracker: the in-flight control bundle
// kept per post-ID stage, and the halt-drain FSM states.
package ctrl_hazard_tracker_pkg;

    typedef logic [4:0] regbits_t;

    typedef struct packed {
        logic     valid;
        logic     regwr;
        logic     memread;
        regbits_t dest;
    } hazard_entry_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } trk_state_t;

endpackage

// File: rtl/ctrl_hazard_tracker_fwd_select.sv
// Priority matcher for one source operand: scans the in-flight entries and
// reports the youngest producer as a forward select, plus whether it is a load too young to forward.
module ctrl_fwd_select
    import ctrl_hazard_tracker_pkg::*;
#(
    parameter int STAGES     = 3,
    parameter int REGS       = 32,
    parameter int LOAD_STAGE = 2,
    parameter int FSW        = 2
) (
    input  hazard_entry_t  entries [STAGES],
    input  regbits_t       rx,
    input  logic           use_rx,
    output logic [FSW-1:0] sel,
    output logic           blocked
);

    logic operand_live;

    assign operand_live = use_rx && (rx != '0) && (int'(rx) < REGS);

    // Oldest to youngest so the youngest match overwrites; load data becomes
    // forwardable once its select value reaches LOAD_STAGE.
    always_comb begin
        sel     = '0;
        blocked = 1'b0;
        for (int s = STAGES - 1; s >= 0; s--) begin
            if (operand_live && entries[s].valid && entries[s].regwr &&
                (entries[s].dest == rx)) begin
                sel     = FSW'(s + 1);
                blocked = entries[s].memread && ((s + 1) < LOAD_STAGE);
            end
        end
    end

endmodule

// File: rtl/ctrl_hazard_tracker.sv
// Hazard/forwarding tracker beside the ID stage: shifts in-flight control bundles,
// drives ID stall, bubble insert, forward selects and the HALT drain sequence.
module ctrl_hazard_tracker
    import ctrl_hazard_tracker_pkg::*;
#(
    parameter  int STAGES     = 3,
    parameter  int REGS       = 32,
    parameter  int LOAD_STAGE = 2,
    localparam int FSW        = $clog2(STAGES + 1)
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           id_valid,
    input  regbits_t       id_rs,
    input  regbits_t       id_rt,
    input  logic           id_use_rs,
    input  logic           id_use_rt,
    input  logic           id_regwr,
    input  regbits_t       id_dest,
    input  logic           id_memread,
    input  logic           id_halt,
    input  logic           ex_flush,
    input  logic           mem_stall,
    output logic           stall_id,
    output logic           bubble,
    output logic [FSW-1:0] fwd_rs_sel,
    output logic [FSW-1:0] fwd_rt_sel,
    output logic           halt_out
);

    hazard_entry_t  entries_q [STAGES];
    hazard_entry_t  entries_d [STAGES];
    trk_state_t     state_q, state_d;
    logic [FSW-1:0] cnt_q, cnt_d;

    hazard_entry_t  ins_entry;
    logic           ins_valid;
    logic           advance;
    logic           rs_blocked;
    logic           rt_blocked;

    ctrl_fwd_select #(
        .STAGES     (STAGES),
        .REGS       (REGS),
        .LOAD_STAGE (LOAD_STAGE),
        .FSW        (FSW)
    ) u_fwd_rs (
        .entries (entries_q),
        .rx      (id_rs),
        .use_rx  (id_use_rs),
        .sel     (fwd_rs_sel),
        .blocked (rs_blocked)
    );

    ctrl_fwd_select #(
        .STAGES     (STAGES),
        .REGS       (REGS),
        .LOAD_STAGE (LOAD_STAGE),
        .FSW        (FSW)
    ) u_fwd_rt (
        .entries (entries_q),
        .rx      (id_rt),
        .use_rx  (id_use_rt),
        .sel     (fwd_rt_sel),
        .blocked (rt_blocked)
    );

    // A flush cancels the load-use stall, but a draining or halted tracker always stalls ID.
    assign advance   = !mem_stall;
    assign stall_id  = (state_q != RUN) || (!ex_flush && (rs_blocked || rt_blocked));
    assign ins_valid = (state_q == RUN) && id_valid && !stall_id && !ex_flush;
    assign bubble    = !ins_valid;
    assign halt_out  = (state_q == HALTED);

    always_comb begin
        ins_entry = '0;
        if (ins_valid) begin
            ins_entry.valid   = 1'b1;
            ins_entry.regwr   = id_regwr;
            ins_entry.memread = id_memread;
            ins_entry.dest    = id_dest;
        end
    end

    always_comb begin
        entries_d = entries_q;
        if (advance) begin
            entries_d[0] = ins_entry;
            for (int i = 1; i < STAGES; i++) begin
                entries_d[i] = entries_q[i - 1];
            end
        end
    end

    // The drain counter only moves on advancing cycles, so a dcache miss stretches the drain.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (advance && ins_valid && id_halt) begin
                    state_d = DRAIN;
                    cnt_d   = FSW'(STAGES);
                end
            end
            DRAIN: begin
                if (advance) begin
                    if (cnt_q <= FSW'(1)) begin
                        cnt_d   = '0;
                        state_d = HALTED;
                    end else begin
                        cnt_d = cnt_q - FSW'(1);
                    end
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            cnt_q   <= '0;
            for (int i = 0; i < STAGES; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            entries_q <= entries_d;
        end
    end

endmodule
